aes_input_packer: RTL

Upstream feeder for the fully pipelined AES-128 encryption core. It accepts a word-serial stream of key and plaintext words and assembles them into 128-bit blocks. For each complete plaintext block it issues a single-cycle strobe carrying the block together with the active cipher key. The core has no backpressure, takes a key with every block, and consumes one block per cycle, so this block presents data_valid_out/plain_text and key_valid_out/cipher_key on the same cycle.

---
 rtl/aes_input_packer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/aes_input_packer.sv
// aes_input_packer: collects a word-serial stream of key and plaintext words
// into 128-bit blocks for a fully pipelined AES-128 core.
//
// Handshake: in_valid qualifies in_is_key/in_data and the word is consumed on
// every rising edge where in_valid=1; there is no ready, so the source never
// stalls. data_valid_out/key_valid_out is a one-cycle strobe with no ready,
// because the core accepts one block per cycle unconditionally.
//
// Words are big-endian: the first word of a group lands in the MSBs.
// The design assumes WORDS = DATA_LEN/WORD_W >= 2.
module aes_input_packer #(
    parameter int WORD_W    = 32,
    parameter int DATA_LEN  = 128,
    parameter int KEY_LEN   = 128,
    parameter int BLK_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic                 in_is_key,
    input  logic [WORD_W-1:0]    in_data,
    output logic                 data_valid_out,
    output logic [DATA_LEN-1:0]  plain_text,
    output logic                 key_valid_out,
    output logic [KEY_LEN-1:0]   cipher_key,
    output logic                 key_loaded,
    output logic                 err_nokey,
    output logic [BLK_CNT_W-1:0] blk_cnt
);

    localparam int WORDS = DATA_LEN / WORD_W;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    if (DATA_LEN != KEY_LEN || (DATA_LEN % WORD_W) != 0) begin : g_bad_params
        $error("aes_input_packer: DATA_LEN must equal KEY_LEN and be a multiple of WORD_W");
    end

    logic [CNT_W-1:0]     key_cnt;
    logic [CNT_W-1:0]     data_cnt;
    logic [KEY_LEN-1:0]   shadow_key;
    logic [KEY_LEN-1:0]   active_key;
    logic [DATA_LEN-1:0]  data_sr;
    logic                 key_loaded_q;
    logic                 err_q;
    logic [BLK_CNT_W-1:0] blk_q;
    logic                 strobe_q;
    logic [DATA_LEN-1:0]  pt_q;
    logic [KEY_LEN-1:0]   ck_q;

    logic key_word;
    logic data_word;
    logic key_done;
    logic data_done;

    // Plaintext words are only taken once a full key is active; the rest are dropped.
    assign key_word  = in_valid &  in_is_key;
    assign data_word = in_valid & ~in_is_key & key_loaded_q;
    assign key_done  = key_word  && (key_cnt  == LAST_WORD);
    assign data_done = data_word && (data_cnt == LAST_WORD);

    // Key path: shift words into the shadow; promote to the active key only on completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_cnt      <= '0;
            shadow_key   <= '0;
            active_key   <= '0;
            key_loaded_q <= 1'b0;
        end else if (clear) begin
            key_cnt      <= '0;
            active_key   <= '0;
            key_loaded_q <= 1'b0;
        end else if (key_word) begin
            shadow_key <= {shadow_key[KEY_LEN-WORD_W-1:0], in_data};
            if (key_done) begin
                key_cnt      <= '0;
                active_key   <= {shadow_key[KEY_LEN-WORD_W-1:0], in_data};
                key_loaded_q <= 1'b1;
            end else begin
                key_cnt <= key_cnt + CNT_W'(1);
            end
        end
    end

    // Data path: shift accepted plaintext words in; a partial block survives key reloads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_cnt <= '0;
            data_sr  <= '0;
        end else if (clear) begin
            data_cnt <= '0;
        end else if (data_word) begin
            data_sr  <= {data_sr[DATA_LEN-WORD_W-1:0], in_data};
            data_cnt <= data_done ? '0 : data_cnt + CNT_W'(1);
        end
    end

    // Output strobe: block and key are registered together and forced to zero when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strobe_q <= 1'b0;
            pt_q     <= '0;
            ck_q     <= '0;
        end else if (!clear && data_done) begin
            strobe_q <= 1'b1;
            pt_q     <= {data_sr[DATA_LEN-WORD_W-1:0], in_data};
            ck_q     <= active_key;
        end else begin
            strobe_q <= 1'b0;
            pt_q     <= '0;
            ck_q     <= '0;
        end
    end

    // Status: sticky no-key error (cleared by clear) and a block counter that clear leaves alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
            blk_q <= '0;
        end else if (clear) begin
            err_q <= 1'b0;
        end else begin
            if (in_valid && !in_is_key && !key_loaded_q) begin
                err_q <= 1'b1;
            end
            if (data_done) begin
                blk_q <= blk_q + BLK_CNT_W'(1);
            end
        end
    end

    assign data_valid_out = strobe_q;
    assign key_valid_out  = strobe_q;
    assign plain_text     = pt_q;
    assign cipher_key     = ck_q;
    assign key_loaded     = key_loaded_q;
    assign err_nokey      = err_q;
    assign blk_cnt        = blk_q;

endmodule
